// File: rtl/io_bridge_pkg.sv
// Shared address map and register decode for the io_bridge CPU data-bus bridge.
// All offsets are byte addresses inside the 4 KiB IO page; the low two bits are ignored.
package io_bridge_pkg;

  localparam logic [19:0] IO_BASE    = 20'hFFFFF;
  localparam logic [11:0] ADDR_DIG   = 12'h000;
  localparam logic [11:0] ADDR_TIMER = 12'h020;
  localparam logic [11:0] ADDR_LED   = 12'h060;
  localparam logic [11:0] ADDR_SW    = 12'h070;
  localparam logic [11:0] ADDR_BTN   = 12'h078;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_DIG,
    REG_TIMER,
    REG_LED,
    REG_SW,
    REG_BTN
  } io_reg_e;

  // Word-granular decode of the page offset.
  function automatic io_reg_e decode_reg(input logic [9:0] word);
    case (word)
      ADDR_DIG[11:2]:   return REG_DIG;
      ADDR_TIMER[11:2]: return REG_TIMER;
      ADDR_LED[11:2]:   return REG_LED;
      ADDR_SW[11:2]:    return REG_SW;
      ADDR_BTN[11:2]:   return REG_BTN;
      default:          return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/io_bridge_if.sv
// CPU data-bus bundle between the single-cycle CPU and io_bridge.
// The CPU drives address/write signals; the bridge returns read data combinationally.
interface io_bridge_if;
  logic [31:0] Bus_addr;
  logic [31:0] Bus_rdata;
  logic        Bus_wen;
  logic [31:0] Bus_wdata;

  modport master (
    output Bus_addr,
    output Bus_wen,
    output Bus_wdata,
    input  Bus_rdata
  );

  modport slave (
    input  Bus_addr,
    input  Bus_wen,
    input  Bus_wdata,
    output Bus_rdata
  );
endinterface

// File: rtl/io_bridge_seg7_decode.sv
// Hex nibble to active-low 7-segment pattern {DP,g,f,e,d,c,b,a}; DP is always dark.
module seg7_decode (
  input  logic [3:0] i_nibble,
  output logic [7:0] o_seg
);

  always_comb begin
    // NOTE: every path assigns o_seg (default arm included) so no latch can be inferred.
    case (i_nibble)
      4'h0:    o_seg = 8'hC0;
      4'h1:    o_seg = 8'hF9;
      4'h2:    o_seg = 8'hA4;
      4'h3:    o_seg = 8'hB0;
      4'h4:    o_seg = 8'h99;
      4'h5:    o_seg = 8'h92;
      4'h6:    o_seg = 8'h82;
      4'h7:    o_seg = 8'hF8;
      4'h8:    o_seg = 8'h80;
      4'h9:    o_seg = 8'h90;
      4'hA:    o_seg = 8'h88;
      4'hB:    o_seg = 8'h83;
      4'hC:    o_seg = 8'hC6;
      4'hD:    o_seg = 8'hA1;
      4'hE:    o_seg = 8'h86;
      default: o_seg = 8'h8E;
    endcase
  end

endmodule

// File: rtl/io_bridge.sv
// Memory-mapped bridge: routes CPU data accesses to DRAM or to the on-board peripheral
// registers (7-seg digits, LEDs, timer, synchronised switches/buttons) and scans the display.
module io_bridge
  import io_bridge_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int SW_W     = 24,
  parameter int BTN_W    = 5
) (
  input  logic             cpu_clk,
  input  logic             cpu_rst,
  io_bridge_if.slave       bus,
  output logic [13:0]      dram_addr,
  input  logic [31:0]      dram_rdata,
  output logic             dram_we,
  output logic [31:0]      dram_wdata,
  input  logic [SW_W-1:0]  sw,
  input  logic [BTN_W-1:0] button,
  output logic [SW_W-1:0]  led,
  output logic [7:0]       dig_en,
  output logic [7:0]       seg
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic             w_io_sel;
  io_reg_e          w_reg;
  logic [31:0]      w_io_rdata;
  logic [3:0]       w_nibble;
  logic [7:0]       w_seg_next;
  logic             w_unused_addr;

  logic [31:0]      r_dig;
  logic [31:0]      r_timer;
  logic [SW_W-1:0]  r_led;
  logic [SW_W-1:0]  r_sw_meta;
  logic [SW_W-1:0]  r_sw_sync;
  logic [BTN_W-1:0] r_btn_meta;
  logic [BTN_W-1:0] r_btn_sync;
  logic [CNT_W-1:0] r_scan_cnt;
  logic [2:0]       r_dig_idx;

  // Region decode; DRAM sees address and data unconditionally, only the strobe is gated.
  assign w_io_sel      = (bus.Bus_addr[31:12] == IO_BASE);
  assign w_reg         = w_io_sel ? decode_reg(bus.Bus_addr[11:2]) : REG_NONE;
  assign w_unused_addr = &{1'b0, bus.Bus_addr[1:0]};

  assign dram_we    = bus.Bus_wen & ~w_io_sel;
  assign dram_addr  = bus.Bus_addr[15:2];
  assign dram_wdata = bus.Bus_wdata;
  assign led        = r_led;

  always_comb begin
    w_io_rdata = '0;
    case (w_reg)
      REG_DIG:   w_io_rdata = r_dig;
      REG_TIMER: w_io_rdata = r_timer;
      REG_LED:   w_io_rdata = 32'(r_led);
      REG_SW:    w_io_rdata = 32'(r_sw_sync);
      REG_BTN:   w_io_rdata = 32'(r_btn_sync);
      default:   w_io_rdata = '0;
    endcase
  end

  assign bus.Bus_rdata = w_io_sel ? w_io_rdata : dram_rdata;

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values together.
    if (cpu_rst) begin
      r_dig   <= '0;
      r_timer <= '0;
      r_led   <= '0;
    end else begin
      if (bus.Bus_wen && w_reg == REG_DIG) r_dig <= bus.Bus_wdata;
      if (bus.Bus_wen && w_reg == REG_LED) r_led <= bus.Bus_wdata[SW_W-1:0];
      // A timer write replaces, rather than precedes, that cycle's increment.
      if (bus.Bus_wen && w_reg == REG_TIMER) r_timer <= bus.Bus_wdata;
      else                                   r_timer <= r_timer + 32'd1;
    end
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      r_sw_meta  <= '0;
      r_sw_sync  <= '0;
      r_btn_meta <= '0;
      r_btn_sync <= '0;
    end else begin
      r_sw_meta  <= sw;
      r_sw_sync  <= r_sw_meta;
      r_btn_meta <= button;
      r_btn_sync <= r_btn_meta;
    end
  end

  // Display scan: the registered outputs always reflect the current digit slot.
  assign w_nibble = r_dig[{r_dig_idx, 2'b00} +: 4];

  seg7_decode u_seg7_decode (
    .i_nibble (w_nibble),
    .o_seg    (w_seg_next)
  );

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      r_scan_cnt <= '0;
      r_dig_idx  <= '0;
      dig_en     <= 8'hFF;
      seg        <= 8'hFF;
    end else begin
      if (r_scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
        r_scan_cnt <= '0;
        r_dig_idx  <= r_dig_idx + 3'd1;
      end else begin
        r_scan_cnt <= r_scan_cnt + CNT_W'(1);
      end
      dig_en <= ~(8'b1 << r_dig_idx);
      seg    <= w_seg_next;
    end
  end

endmodule
